// File: rtl/xcorr_lag_engine.sv
// Streaming valid-mode cross-correlation: loads A (M) and B (N), then emits r[k] for k = 0..M-N, one MAC per cycle.
// Optional running-peak tracking (peak_val/peak_lag) is compiled in when XCORR_PEAK_EN is defined.
module xcorr_lag_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int M          = 64,
  parameter int N          = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int LAG_WIDTH  = $clog2(M - N + 1) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  abort,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [LAG_WIDTH-1:0]  out_lag,
  output logic                  out_last,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
`ifdef XCORR_PEAK_EN
  ,
  output logic [ACC_WIDTH-1:0]  peak_val,
  output logic [LAG_WIDTH-1:0]  peak_lag
`endif
);

  localparam int L  = M - N + 1;
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_WIDTH;

  // Handshakes: a beat/result transfers on a cycle where valid and ready are both high;
  // the producer holds valid and data stable until that cycle. abort discards any such transfer.

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_MAC    = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [DATA_WIDTH-1:0] r_mem_a [0:(2**AW)-1];
  logic signed [DATA_WIDTH-1:0] r_mem_b [0:(2**BW)-1];

  logic [AW-1:0]        r_idx;
  logic [BW-1:0]        r_i;
  logic [AW-1:0]        r_k;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic [LAG_WIDTH-1:0] r_out_lag;
  logic                 r_out_last;
  logic                 r_out_valid;
  logic                 r_frame_done;

  logic                         w_a_ready;
  logic                         w_b_ready;
  logic                         w_a_fire;
  logic                         w_b_fire;
  logic                         w_out_fire;
  logic                         w_mac_last;
  logic                         w_lag_last;
  logic [AW-1:0]                w_a_addr;
  logic signed [DATA_WIDTH-1:0] w_a_s;
  logic signed [DATA_WIDTH-1:0] w_b_s;
  logic signed [PW-1:0]         w_prod;
  logic [ACC_WIDTH-1:0]         w_prod_ext;
  logic [ACC_WIDTH-1:0]         w_sum;

  assign w_a_fire   = a_valid & w_a_ready;
  assign w_b_fire   = b_valid & w_b_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_mac_last = (r_i == BW'(N - 1));
  assign w_lag_last = (r_k == AW'(L - 1));

  // Sliding window: lag k reads A[i+k] against B[i].
  assign w_a_addr   = AW'(r_i) + r_k;
  assign w_a_s      = r_mem_a[w_a_addr];
  assign w_b_s      = r_mem_b[r_i];
  assign w_prod     = w_a_s * w_b_s;
  assign w_prod_ext = {{(ACC_WIDTH - PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_a_ready = 1'b1;
        if (a_valid && (r_idx == AW'(M - 1))) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_b_ready = 1'b1;
        if (b_valid && (r_idx == AW'(N - 1))) w_next = S_MAC;
      end
      S_MAC: begin
        if (w_mac_last) w_next = S_EMIT;
      end
      S_EMIT: begin
        if (w_out_fire) w_next = w_lag_last ? S_LOAD_A : S_MAC;
      end
      default: w_next = S_LOAD_A;
    endcase
    if (abort) w_next = S_LOAD_A;
  end

  // Sample stores carry no reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (w_a_fire && !abort) r_mem_a[r_idx] <= a_data;
    if (w_b_fire && !abort) r_mem_b[r_idx[BW-1:0]] <= b_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_i          <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_out_lag    <= '0;
      r_out_last   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (abort) begin
        r_idx       <= '0;
        r_i         <= '0;
        r_k         <= '0;
        r_acc       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD_A: begin
            if (w_a_fire) r_idx <= (r_idx == AW'(M - 1)) ? '0 : r_idx + AW'(1);
          end
          S_LOAD_B: begin
            if (w_b_fire) begin
              if (r_idx == AW'(N - 1)) begin
                r_idx <= '0;
                r_i   <= '0;
                r_k   <= '0;
                r_acc <= '0;
              end else begin
                r_idx <= r_idx + AW'(1);
              end
            end
          end
          S_MAC: begin
            // Final product is folded straight into the output register.
            if (w_mac_last) begin
              r_out_data  <= w_sum;
              r_out_lag   <= LAG_WIDTH'(r_k);
              r_out_last  <= w_lag_last;
              r_out_valid <= 1'b1;
            end else begin
              r_acc <= w_sum;
              r_i   <= r_i + BW'(1);
            end
          end
          S_EMIT: begin
            if (w_out_fire) begin
              r_out_valid <= 1'b0;
              r_i         <= '0;
              r_acc       <= '0;
              if (w_lag_last) begin
                r_k          <= '0;
                r_frame_done <= 1'b1;
              end else begin
                r_k <= r_k + AW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef XCORR_PEAK_EN
  logic [ACC_WIDTH-1:0] r_run_val;
  logic [LAG_WIDTH-1:0] r_run_lag;
  logic [ACC_WIDTH-1:0] r_peak_val;
  logic [LAG_WIDTH-1:0] r_peak_lag;
  logic                 w_take;
  logic [ACC_WIDTH-1:0] w_best_val;
  logic [LAG_WIDTH-1:0] w_best_lag;

  // Lag 0 seeds the running max; afterwards only a strictly larger value wins.
  assign w_take     = (r_k == '0) || ($signed(r_out_data) > $signed(r_run_val));
  assign w_best_val = w_take ? r_out_data : r_run_val;
  assign w_best_lag = w_take ? r_out_lag : r_run_lag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_val  <= '0;
      r_run_lag  <= '0;
      r_peak_val <= '0;
      r_peak_lag <= '0;
    end else if (w_out_fire && !abort) begin
      r_run_val <= w_best_val;
      r_run_lag <= w_best_lag;
      if (r_out_last) begin
        r_peak_val <= w_best_val;
        r_peak_lag <= w_best_lag;
      end
    end
  end

  assign peak_val = r_peak_val;
  assign peak_lag = r_peak_lag;
`endif

  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_lag    = r_out_lag;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule
